// File: rtl/fir_cap_pkg.sv
// Shared types and helpers for the FIR output capture stage.
package fir_cap_pkg;

   localparam int DW_DEF = 16;
   localparam int OW_DEF = 32;
   localparam int IW_DEF = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } cap_state_e;

   function automatic logic [OW_DEF-1:0] sign_ext(input logic [DW_DEF-1:0] x);
      return {{(OW_DEF-DW_DEF){x[DW_DEF-1]}}, x};
   endfunction

endpackage

// File: rtl/fir_out_capture_sync_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when a pop frees the slot on the same edge.
module sync_fifo #(
   parameter int W     = 48,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               wdata,
   output logic [W-1:0]               rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage carries no reset; the consumer masks the head while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign level = count;

endmodule

// File: rtl/fir_out_capture.sv
// Capture stage: drops filter fill samples, decimates, tags and buffers kept samples for the logger.
//   state | meaning
//   IDLE  | waiting for en; FIFO contents retained
//   FILL  | discarding SKIP valid samples of filter transient
//   RUN   | candidates decimated, kept samples pushed
//   DONE  | NCAP samples kept; inputs ignored until en drops
module fir_out_capture
   import fir_cap_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int OW    = OW_DEF,
   parameter int IW    = IW_DEF,
   parameter int DEPTH = 16,
   parameter int SKIP  = 8,
   parameter int NCAP  = 4096
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [3:0]             decim,
   input  logic [DW-1:0]          yin,
   input  logic                   yin_valid,
   output logic [OW-1:0]          m_data,
   output logic [IW-1:0]          m_index,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   done
);
   localparam int SW = (SKIP > 1) ? $clog2(SKIP) : 1;
   localparam int CW = (NCAP > 1) ? $clog2(NCAP) : 1;

   cap_state_e    state, state_nxt;
   logic [SW-1:0] skip_cnt;
   logic [IW-1:0] idx_cnt;
   logic [3:0]    dec_cnt;
   logic [3:0]    dec_max;
   logic [CW-1:0] cap_cnt;

   logic start, enter_run, skip_inc, cand, last, keep, push;
   logic fifo_full, fifo_empty, pop;
   logic [OW+IW-1:0] fifo_rdata;

   assign keep = (dec_cnt == 4'd0);
   assign push = cand & keep;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      enter_run = 1'b0;
      skip_inc  = 1'b0;
      cand      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               start = 1'b1;
               if (SKIP == 0) begin
                  state_nxt = RUN;
                  enter_run = 1'b1;
               end else begin
                  state_nxt = FILL;
               end
            end
         end
         FILL: begin
            if (yin_valid) begin
               if (skip_cnt == SW'(SKIP-1)) begin
                  state_nxt = RUN;
                  enter_run = 1'b1;
               end else begin
                  skip_inc = 1'b1;
               end
            end
            if (!en) state_nxt = IDLE;
         end
         RUN: begin
            if (yin_valid) begin
               cand = 1'b1;
               if (keep && (NCAP != 0) && (cap_cnt == CW'(NCAP-1))) begin
                  last      = 1'b1;
                  state_nxt = DONE;
               end
            end
            if (!en) state_nxt = IDLE;
         end
         DONE: begin
            if (!en) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A dropped kept sample still counts toward NCAP so run length is fixed in input time.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         skip_cnt <= '0;
         idx_cnt  <= '0;
         dec_cnt  <= '0;
         dec_max  <= '0;
         cap_cnt  <= '0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (start) begin
            skip_cnt <= '0;
            idx_cnt  <= '0;
            dec_cnt  <= '0;
            cap_cnt  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
         end
         if (skip_inc)  skip_cnt <= skip_cnt + 1'b1;
         if (enter_run) dec_max  <= (decim > 4'd1) ? (decim - 4'd1) : 4'd0;
         if (cand) begin
            idx_cnt <= idx_cnt + 1'b1;
            dec_cnt <= (dec_cnt == dec_max) ? 4'd0 : (dec_cnt + 4'd1);
         end
         if (push) begin
            cap_cnt <= cap_cnt + 1'b1;
            if (fifo_full && !pop) overflow <= 1'b1;
         end
         if (last) done <= 1'b1;
      end
   end

   assign pop = m_valid & m_ready;

   sync_fifo #(.W(OW+IW), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({sign_ext(yin), idx_cnt}),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign m_valid = ~fifo_empty;
   assign m_data  = m_valid ? fifo_rdata[OW+IW-1:IW] : '0;
   assign m_index = m_valid ? fifo_rdata[IW-1:0]     : '0;

endmodule

// File: tb/tb_fir_out_capture.sv
// Directed and randomized checks of fir_out_capture against a queue-based reference model.
module tb_fir_out_capture;
   import fir_cap_pkg::*;

   localparam int SKIP  = 8;
   localparam int DEPTH = 16;
   localparam int NCAP  = 4096;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [3:0]  decim = 4'd1;
   logic [15:0] yin = '0;
   logic        yin_valid = 1'b0;
   logic        m_ready = 1'b0;

   logic [31:0] a_data,  b_data;
   logic [15:0] a_index, b_index;
   logic        a_valid, b_valid, a_ovf, b_ovf, a_done, b_done;
   logic [4:0]  a_level, b_level;

   int ntot = 0;
   int npass = 0;

   always #5 clk = ~clk;

   fir_out_capture dut_a (
      .clk(clk), .rst(rst), .en(en), .decim(decim), .yin(yin), .yin_valid(yin_valid),
      .m_data(a_data), .m_index(a_index), .m_valid(a_valid), .m_ready(m_ready),
      .level(a_level), .overflow(a_ovf), .done(a_done));

   fir_out_capture #(.NCAP(5)) dut_b (
      .clk(clk), .rst(rst), .en(en), .decim(decim), .yin(yin), .yin_valid(yin_valid),
      .m_data(b_data), .m_index(b_index), .m_valid(b_valid), .m_ready(m_ready),
      .level(b_level), .overflow(b_ovf), .done(b_done));

   // Reference model for dut_a: run phase, sample tallies and the expected FIFO contents.
   int          ph, skipped, cand_n, kept, dfac;
   bit          ovf, dn;
   logic [47:0] q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      ntot++;
      assert (obs === exp) npass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] sx(input logic [15:0] v);
      logic signed [31:0] s;
      s = $signed(v);
      return s;
   endfunction

   task automatic model_reset();
      ph = 0; skipped = 0; cand_n = 0; kept = 0; dfac = 1; ovf = 0; dn = 0;
      q.delete();
   endtask

   task automatic model_edge();
      bit pop, do_push;
      logic [47:0] ent;
      pop = (q.size() != 0) && m_ready;
      do_push = 0;
      ent = '0;
      case (ph)
         0: if (en) begin
               skipped = 0; cand_n = 0; kept = 0; ovf = 0; dn = 0; ph = 1;
            end
         1: begin
               if (yin_valid) begin
                  skipped++;
                  if (skipped == SKIP) begin
                     ph = 2;
                     dfac = (decim < 2) ? 1 : int'(decim);
                  end
               end
               if (!en) ph = 0;
            end
         2: begin
               if (yin_valid) begin
                  if ((cand_n % dfac) == 0) begin
                     if (int'(q.size()) - int'(pop) < DEPTH) begin
                        do_push = 1;
                        ent = {sx(yin), 16'(cand_n % 65536)};
                     end else begin
                        ovf = 1;
                     end
                     kept++;
                     if (kept == NCAP) begin ph = 3; dn = 1; end
                  end
                  cand_n++;
               end
               if (!en) ph = 0;
            end
         default: if (!en) ph = 0;
      endcase
      if (pop) void'(q.pop_front());
      if (do_push) q.push_back(ent);
   endtask

   task automatic compare_a();
      chk("a_valid", 64'(a_valid), 64'(q.size() != 0));
      chk("a_level", 64'(a_level), 64'(q.size()));
      if (q.size() != 0) begin
         chk("a_data",  64'(a_data),  64'(q[0][47:16]));
         chk("a_index", 64'(a_index), 64'(q[0][15:0]));
      end
      chk("a_overflow", 64'(a_ovf), 64'(ovf));
      chk("a_done",     64'(a_done), 64'(dn));
   endtask

   task automatic step(input bit e, input logic [3:0] d, input logic [15:0] y, input bit v, input bit r);
      en = e; decim = d; yin = y; yin_valid = v; m_ready = r;
      @(posedge clk);
      model_edge();
      #1;
      compare_a();
   endtask

   task automatic do_reset();
      rst = 0; en = 0; yin_valid = 0; m_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      compare_a();
      chk("rst_data",    64'(a_data),  64'(0));
      chk("rst_index",   64'(a_index), 64'(0));
      chk("rst_b_level", 64'(b_level), 64'(0));
      chk("rst_b_valid", 64'(b_valid), 64'(0));
      chk("rst_state",   64'(dut_a.state), 64'(IDLE));
      rst = 1;
   endtask

   task automatic start_run(input logic [3:0] d);
      step(1, d, 16'h0, 0, 0);
      for (int i = 0; i < SKIP; i++) step(1, d, 16'($urandom), 1, 0);
   endtask

   initial begin
      logic [15:0] rec [18];
      logic [15:0] ylast;

      // reset and start: samples 1..8 are fill transient
      do_reset();
      step(1, 4'd1, 16'h0, 0, 0);
      for (int i = 1; i <= 12; i++) step(1, 4'd1, 16'(i), 1, 0);
      chk("start_level", 64'(a_level), 64'(4));
      for (int k = 0; k < 4; k++) begin
         chk("start_data",  64'(a_data),  64'(9 + k));
         chk("start_index", 64'(a_index), 64'(k));
         step(1, 4'd1, 16'h0, 0, 1);
      end

      // sign extension
      do_reset();
      start_run(4'd1);
      step(1, 4'd1, 16'h8000, 1, 0);
      step(1, 4'd1, 16'hFFFF, 1, 0);
      step(1, 4'd1, 16'h7FFF, 1, 0);
      chk("sext_8000", 64'(a_data), 64'h0000_0000_FFFF_8000);
      step(1, 4'd1, 16'h0, 0, 1);
      chk("sext_ffff", 64'(a_data), 64'h0000_0000_FFFF_FFFF);
      step(1, 4'd1, 16'h0, 0, 1);
      chk("sext_7fff", 64'(a_data), 64'h0000_0000_0000_7FFF);
      step(1, 4'd1, 16'h0, 0, 1);

      // decimation by 4, decim changed mid-run must be ignored
      do_reset();
      start_run(4'd4);
      for (int i = 0; i < 16; i++) step(1, (i < 8) ? 4'd4 : 4'd2, 16'(i), 1, 0);
      chk("decim_level", 64'(a_level), 64'(4));
      for (int k = 0; k < 4; k++) begin
         chk("decim_index", 64'(a_index), 64'(4 * k));
         chk("decim_data",  64'(a_data),  64'(4 * k));
         step(1, 4'd4, 16'h0, 0, 1);
      end

      // full FIFO, overflow, simultaneous push/pop when full
      do_reset();
      start_run(4'd1);
      for (int i = 0; i < 17; i++) begin
         rec[i] = 16'($urandom);
         step(1, 4'd1, rec[i], 1, 0);
      end
      chk("full_level",    64'(a_level), 64'(16));
      chk("full_overflow", 64'(a_ovf),   64'(1));
      chk("full_head",     64'(a_data),  64'(sx(rec[0])));
      ylast = 16'($urandom);
      step(1, 4'd1, ylast, 1, 1);
      chk("full_pushpop_level", 64'(a_level), 64'(16));
      for (int k = 0; k < 16; k++) begin
         if (k == 15) begin
            chk("full_tail_index", 64'(a_index), 64'(17));
            chk("full_tail_data",  64'(a_data),  64'(sx(ylast)));
         end
         step(1, 4'd1, 16'h0, 0, 1);
      end
      chk("full_drained", 64'(a_level), 64'(0));

      // NCAP=5 instance: done, inputs ignored, restart
      do_reset();
      start_run(4'd1);
      for (int i = 0; i < 8; i++) step(1, 4'd1, 16'(100 + i), 1, 0);
      chk("ncap_level", 64'(b_level), 64'(5));
      chk("ncap_done",  64'(b_done),  64'(1));
      chk("ncap_head",  64'(b_data),  64'(100));
      chk("ncap_index", 64'(b_index), 64'(0));
      step(0, 4'd1, 16'h0, 0, 0);
      chk("ncap_done_held", 64'(b_done), 64'(1));
      start_run(4'd1);
      chk("ncap_done_clear", 64'(b_done), 64'(0));
      for (int k = 0; k < 5; k++) step(1, 4'd1, 16'h0, 0, 1);
      step(1, 4'd1, 16'h0055, 1, 0);
      chk("ncap_restart_level", 64'(b_level), 64'(1));
      chk("ncap_restart_index", 64'(b_index), 64'(0));
      chk("ncap_restart_data",  64'(b_data),  64'(16'h0055));

      // randomized traffic including en drops and mid-run decim changes
      do_reset();
      start_run(4'($urandom_range(0, 15)));
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(0, 59) != 0, 4'($urandom_range(0, 15)), 16'($urandom),
              $urandom_range(0, 3) != 0, (i % 100 < 30) ? 1'b0 : ($urandom_range(0, 2) != 0));
      end

      // asynchronous reset between edges with level 7
      do_reset();
      start_run(4'd1);
      for (int i = 0; i < 7; i++) step(1, 4'd1, 16'($urandom), 1, 0);
      chk("async_pre_level", 64'(a_level), 64'(7));
      #2 rst = 0;
      #1;
      chk("async_valid", 64'(a_valid), 64'(0));
      chk("async_level", 64'(a_level), 64'(0));
      chk("async_state", 64'(dut_a.state), 64'(IDLE));
      model_reset();
      en = 0;
      @(posedge clk);
      #1 rst = 1;
      compare_a();

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

endmodule
